// File: rtl/ibex_data_bus_arbiter_if.sv
// Ibex data bus bundle: req/gnt address phase, rvalid/err/rdata response phase.
// Latency: none, this is a signal bundle only.
// Backpressure: the slave side holds off an address phase by withholding gnt.
interface ibex_data_bus;
    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, err, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, err, rdata);
endinterface

// File: rtl/ibex_data_bus_arbiter.sv
// Round-robin 2:1 ibex data bus arbiter, one outstanding transaction in total.
// Latency: zero added cycles on both the address phase and the response path.
// Backpressure: the loser (and everyone during RESP) sees gnt=0 until the bus frees.
// Optional response watchdog: define IBEX_DATA_BUS_ARBITER_TIMEOUT_EN.
module ibex_data_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic          clk,
    input logic          rst,
    ibex_data_bus.slave  m0,
    ibex_data_bus.slave  m1,
    ibex_data_bus.master s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic        sel;
    logic        owner_req;
    logic        fwd_en;
    logic        fwd_sel;
    logic        rsp_en;
    logic        rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        timeout_hit;

    // Legal TIMEOUT_CYCLES is 1..65535; an illegal value shows up as this block in the hierarchy.
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_timeout_cycles_out_of_range
    end

`ifdef IBEX_DATA_BUS_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_cnt_q;

    assign timeout_hit = (state_q == RESP) && !s.rvalid && (to_cnt_q == TIMEOUT_LAST);

    // Count RESP cycles that pass without a slave response; held at zero outside RESP.
    always_ff @(posedge clk) begin
        if (rst || state_q != RESP) begin
            to_cnt_q <= '0;
        end else if (!s.rvalid) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A real slave response wins over a same-cycle watchdog expiry.
    assign rsp_vld   = rsp_en && (s.rvalid || timeout_hit);
    assign rsp_err   = s.rvalid ? s.err : 1'b1;
    assign rsp_rdata = s.rvalid ? s.rdata : 32'h0;
    assign owner_req = owner_q ? m1.req : m0.req;

    // Arbitration in IDLE, address-phase lock in ADDR, response wait in RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        fwd_en  = 1'b0;
        fwd_sel = owner_q;
        rsp_en  = 1'b0;
        sel     = prio_q;
        if (m0.req != m1.req) begin
            sel = m1.req;
        end
        case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    fwd_en  = 1'b1;
                    fwd_sel = sel;
                    owner_d = sel;
                    state_d = s.gnt ? RESP : ADDR;
                end
            end
            ADDR: begin
                fwd_en = 1'b1;
                if (s.gnt && owner_req) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_en = 1'b1;
                if (s.rvalid || timeout_hit) begin
                    state_d = IDLE;
                    prio_d  = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus steering: selected master's address phase to s, response to the owner; all quiet in reset.
    always_comb begin
        s.req     = 1'b0;
        s.addr    = '0;
        s.we      = 1'b0;
        s.be      = '0;
        s.wdata   = '0;
        m0.gnt    = 1'b0;
        m0.rvalid = 1'b0;
        m0.err    = 1'b0;
        m0.rdata  = '0;
        m1.gnt    = 1'b0;
        m1.rvalid = 1'b0;
        m1.err    = 1'b0;
        m1.rdata  = '0;
        if (!rst) begin
            if (fwd_en) begin
                if (fwd_sel) begin
                    s.req   = m1.req;
                    s.addr  = m1.addr;
                    s.we    = m1.we;
                    s.be    = m1.be;
                    s.wdata = m1.wdata;
                    m1.gnt  = s.gnt && m1.req;
                end else begin
                    s.req   = m0.req;
                    s.addr  = m0.addr;
                    s.we    = m0.we;
                    s.be    = m0.be;
                    s.wdata = m0.wdata;
                    m0.gnt  = s.gnt && m0.req;
                end
            end
            if (rsp_vld) begin
                if (owner_q) begin
                    m1.rvalid = 1'b1;
                    m1.err    = rsp_err;
                    m1.rdata  = rsp_rdata;
                end else begin
                    m0.rvalid = 1'b1;
                    m0.err    = rsp_err;
                    m0.rdata  = rsp_rdata;
                end
            end
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_ibex_data_bus_arbiter.sv
// Directed bench for ibex_data_bus_arbiter with a queue-based scoreboard.
// Latency: expected events carry the cycle in which they must appear.
// Backpressure: the slave side is driven cycle by cycle from the stimulus.
module tb_ibex_data_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_data_bus m0_bus ();
    ibex_data_bus m1_bus ();
    ibex_data_bus s_bus ();

    ibex_data_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_bus),
        .m1  (m1_bus),
        .s   (s_bus)
    );

    typedef struct {
        int          cyc;
        logic        mid;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          cyc;
        logic        mid;
        logic        err;
        logic [31:0] rdata;
    } rsp_exp_t;

    gnt_exp_t gq[$];
    rsp_exp_t rq[$];

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input bit idx, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wdata);
        if (idx) begin
            m1_bus.addr = addr; m1_bus.we = we; m1_bus.be = be; m1_bus.wdata = wdata;
        end else begin
            m0_bus.addr = addr; m0_bus.we = we; m0_bus.be = be; m0_bus.wdata = wdata;
        end
    endtask

    task automatic drive(input logic r, input logic q0, input logic q1, input logic sg,
                         input logic sv, input logic se, input logic [31:0] sd);
        rst          = r;
        m0_bus.req   = q0;
        m1_bus.req   = q1;
        s_bus.gnt    = sg;
        s_bus.rvalid = sv;
        s_bus.err    = se;
        s_bus.rdata  = sd;
    endtask

    task automatic push_gnt(input logic mid, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata);
        gnt_exp_t g;
        g.cyc = cyc; g.mid = mid; g.addr = addr; g.we = we; g.be = be; g.wdata = wdata;
        gq.push_back(g);
    endtask

    task automatic push_rsp(input logic mid, input logic err, input logic [31:0] rdata);
        rsp_exp_t r;
        r.cyc = cyc; r.mid = mid; r.err = err; r.rdata = rdata;
        rq.push_back(r);
    endtask

    // Monitor: pops the scoreboard whenever a master sees gnt or rvalid, and flags missed events.
    always @(negedge clk) begin
        gnt_exp_t g;
        rsp_exp_t r;
        if (gq.size() != 0 && gq[0].cyc < cyc) begin
            g = gq.pop_front();
            check("gnt_missed_cycle", 128'(cyc), 128'(g.cyc));
        end
        if (rq.size() != 0 && rq[0].cyc < cyc) begin
            r = rq.pop_front();
            check("rsp_missed_cycle", 128'(cyc), 128'(r.cyc));
        end
        if (m0_bus.gnt || m1_bus.gnt) begin
            if (gq.size() == 0) begin
                check("gnt_unexpected", {m0_bus.gnt, m1_bus.gnt}, 128'(0));
            end else begin
                g = gq.pop_front();
                check("gnt_event",
                      {m0_bus.gnt, m1_bus.gnt, 32'(cyc), s_bus.req, s_bus.addr, s_bus.we, s_bus.be, s_bus.wdata},
                      {~g.mid, g.mid, 32'(g.cyc), 1'b1, g.addr, g.we, g.be, g.wdata});
            end
        end
        if (m0_bus.rvalid || m1_bus.rvalid) begin
            if (rq.size() == 0) begin
                check("rsp_unexpected", {m0_bus.rvalid, m1_bus.rvalid}, 128'(0));
            end else begin
                r = rq.pop_front();
                if (r.mid) begin
                    check("rsp_event",
                          {m0_bus.rvalid, m1_bus.rvalid, 32'(cyc), m1_bus.err, m1_bus.rdata, m0_bus.err, m0_bus.rdata},
                          {1'b0, 1'b1, 32'(r.cyc), r.err, r.rdata, 1'b0, 32'h0});
                end else begin
                    check("rsp_event",
                          {m0_bus.rvalid, m1_bus.rvalid, 32'(cyc), m0_bus.err, m0_bus.rdata, m1_bus.err, m1_bus.rdata},
                          {1'b1, 1'b0, 32'(r.cyc), r.err, r.rdata, 1'b0, 32'h0});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every input active: outputs must be forced quiet.
        set_m(0, 32'hFFFF_0000, 1'b1, 4'hF, 32'h1111_1111);
        set_m(1, 32'hEEEE_0000, 1'b1, 4'hF, 32'h2222_2222);
        drive(1, 1, 1, 1, 1, 1, 32'h9999_9999);
        step(); step();
        #2;
        check("rst_s_bus", {s_bus.req, s_bus.we, s_bus.be, s_bus.addr, s_bus.wdata}, 128'(0));
        check("rst_m_ctrl", {m0_bus.gnt, m0_bus.rvalid, m0_bus.err, m1_bus.gnt, m1_bus.rvalid, m1_bus.err}, 128'(0));
        check("rst_m_rdata", {m0_bus.rdata, m1_bus.rdata}, 128'(0));
        step();

        // m0 write, immediate gnt, rvalid one cycle later.
        set_m(0, 32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        push_gnt(0, 32'h0000_1000, 1'b1, 4'hF, 32'hDEAD_BEEF);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h0);
        push_rsp(0, 1'b0, 32'h0);
        step();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();

        // m1 read held off 3 cycles; m0 joins and must wait for m1's response.
        set_m(1, 32'h0000_2004, 1'b0, 4'hF, 32'h0);
        set_m(0, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
        drive(0, 0, 1, 0, 0, 0, 32'h0);
        #2;
        check("addr_lock_c0", {s_bus.req, s_bus.addr}, {1'b1, 32'h0000_2004});
        step();
        drive(0, 1, 1, 0, 1, 0, 32'hABCD_0000);   // spurious rvalid in ADDR
        #2;
        check("addr_lock_c1", {s_bus.req, s_bus.addr}, {1'b1, 32'h0000_2004});
        step();
        drive(0, 1, 1, 0, 0, 0, 32'h0);
        #2;
        check("addr_lock_c2", {s_bus.req, s_bus.addr}, {1'b1, 32'h0000_2004});
        step();
        drive(0, 1, 1, 1, 0, 0, 32'h0);
        push_gnt(1, 32'h0000_2004, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 1, 0, 0, 1, 0, 32'hAAAA_0001);
        push_rsp(1, 1'b0, 32'hAAAA_0001);
        step();
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        push_gnt(0, 32'h0000_3000, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h5555_0002);
        push_rsp(0, 1'b0, 32'h5555_0002);
        step();

        // m1 read answered with an error.
        set_m(1, 32'h0000_4008, 1'b0, 4'hF, 32'h0);
        drive(0, 0, 1, 1, 0, 0, 32'h0);
        push_gnt(1, 32'h0000_4008, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 0, 0, 0, 1, 1, 32'h1234_5678);
        push_rsp(1, 1'b1, 32'h1234_5678);
        #2;
        check("err_m0_rdata_quiet", {m0_bus.rvalid, m0_bus.err, m0_bus.rdata}, 128'(0));
        step();

        // Spurious rvalid while idle must not reach anyone.
        drive(0, 0, 0, 0, 1, 1, 32'hFFFF_FFFF);
        #2;
        check("spurious_idle_rvalid", {m0_bus.rvalid, m1_bus.rvalid, m0_bus.err, m1_bus.err, m0_bus.rdata, m1_bus.rdata}, 128'(0));
        step();

        // Both masters request continuously: strict alternation m0, m1, m0, m1, 2 cycles each.
        set_m(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
        set_m(1, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 1, 1, 0, 0, 32'h0);
            push_gnt(k[0], k[0] ? 32'h0000_0200 : 32'h0000_0100, 1'b0, 4'hF, 32'h0);
            step();
            drive(0, 1, 1, 0, 1, 0, 32'hC0DE_0000 + 32'(k));
            push_rsp(k[0], 1'b0, 32'hC0DE_0000 + 32'(k));
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();

        // m0-only transaction leaves the tie pointer on m1.
        set_m(0, 32'h0000_0400, 1'b0, 4'hF, 32'h0);
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        push_gnt(0, 32'h0000_0400, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h0000_0404);
        push_rsp(0, 1'b0, 32'h0000_0404);
        step();

        // Reset during m0's RESP: in-flight response dropped, tie returns to m0.
        set_m(0, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        push_gnt(0, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
        step();
        drive(1, 0, 0, 0, 1, 0, 32'h7777_7777);
        #2;
        check("rst_in_resp_quiet", {m0_bus.rvalid, m1_bus.rvalid, m0_bus.rdata, m1_bus.rdata}, 128'(0));
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h7777_7777);
        #2;
        check("late_rvalid_dropped", {m0_bus.rvalid, m1_bus.rvalid, m0_bus.rdata, m1_bus.rdata}, 128'(0));
        step();
        set_m(0, 32'h0000_0600, 1'b0, 4'hF, 32'h0);
        set_m(1, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
        drive(0, 1, 1, 1, 0, 0, 32'h0);
        push_gnt(0, 32'h0000_0600, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h0000_0606);
        push_rsp(0, 1'b0, 32'h0000_0606);
        step();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();

`ifdef IBEX_DATA_BUS_ARBITER_TIMEOUT_EN
        // Slave never answers m0: error response 8 cycles after the grant, then m1 is served.
        set_m(0, 32'h0000_0800, 1'b0, 4'hF, 32'h0);
        set_m(1, 32'h0000_0900, 1'b0, 4'hF, 32'h0);
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        push_gnt(0, 32'h0000_0800, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 0, 1, 0, 0, 0, 32'hBAD0_BAD0);
        for (int i = 1; i <= 8; i++) begin
            if (i == 8) push_rsp(0, 1'b1, 32'h0);
            step();
        end
        drive(0, 0, 1, 1, 0, 0, 32'h0);
        push_gnt(1, 32'h0000_0900, 1'b0, 4'hF, 32'h0);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h0000_4242);
        push_rsp(1, 1'b0, 32'h0000_4242);
        step();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        step();
`endif

        step(); step();
        check("gnt_queue_drained", 128'(gq.size()), 128'(0));
        check("rsp_queue_drained", 128'(rq.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
